// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the oversampling UART receiver.
//                Parity mode codes, receiver state encoding and a counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Bits needed to count 0..cycles-1 (never less than one bit).
    function automatic int cyc_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_sampler
//  Description : 2-flop input synchroniser, falling-edge detect and 3-tap
//                majority vote around the bit centre.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                signal_in     - asynchronous RX line (idles high)
//                cyc           - bit-phase counter from the receiver FSM
//                s_in          - synchronised line
//                fall          - s_in went 1 -> 0 this cycle
//                bit_dec       - majority of taps MID-1, MID and live s_in;
//                                valid in the cycle cyc == MID+1
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_SYMBOL = 16,
    parameter int CYC_W             = cyc_width(CYCLES_PER_SYMBOL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal_in,
    input  logic [CYC_W-1:0] cyc,
    output logic             s_in,
    output logic             fall,
    output logic             bit_dec
);

    localparam int               c_MID  = (CYCLES_PER_SYMBOL - 1) >> 1;
    localparam logic [CYC_W-1:0] c_TAP0 = CYC_W'(c_MID - 1);
    localparam logic [CYC_W-1:0] c_TAP1 = CYC_W'(c_MID);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_tap0;
    logic r_tap1;

    // Synchroniser and edge register preset to the idle level so that a
    // reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_tap0  <= 1'b1;
            r_tap1  <= 1'b1;
        end else begin
            r_sync1 <= signal_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (cyc == c_TAP0) r_tap0 <= r_sync2;
            if (cyc == c_TAP1) r_tap1 <= r_sync2;
        end
    end

    assign s_in    = r_sync2;
    assign fall    = r_prev & ~r_sync2;
    // Third tap is the live sample, so the vote is ready at cyc == MID+1.
    assign bit_dec = (r_tap0 & r_tap1) | (r_tap0 & r_sync2) | (r_tap1 & r_sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : Oversampling UART receiver with configurable data width,
//                parity and stop bits, start-glitch rejection, error flags
//                and a valid/ready output with overrun reporting.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                signal_in     - asynchronous RX line (idles high)
//                data_out      - received word, bit 0 = first data bit
//                data_valid    - data_out holds an unconsumed word
//                data_ready    - sink accepts the word while data_valid
//                parity_err    - parity mismatch in the held word
//                frame_err     - a stop bit of the held word sampled low
//                overrun       - 1-cycle pulse when a completed frame drops
//                busy          - receiver is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_SYMBOL = 125_000_000 / 115_200,
    parameter int DATA_BITS         = 8,
    parameter int PARITY            = 0,
    parameter int STOP_BITS         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_CYC_W   = cyc_width(CYCLES_PER_SYMBOL);
    localparam int c_MID     = (CYCLES_PER_SYMBOL - 1) >> 1;
    localparam int c_BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int c_BIT_W   = cyc_width(c_BIT_MAX);

    localparam logic [c_CYC_W-1:0] c_DEC_CYC   = c_CYC_W'(c_MID + 1);
    localparam logic [c_CYC_W-1:0] c_LAST_CYC  = c_CYC_W'(CYCLES_PER_SYMBOL - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);

    generate
        if (CYCLES_PER_SYMBOL < 4) begin : g_bad_cps
            $error("uart_rx_os: CYCLES_PER_SYMBOL must be >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_rx_os: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_os: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1) begin : g_bad_stop
            $error("uart_rx_os: STOP_BITS must be >= 1");
        end
    endgenerate

    rx_state_t              r_state;
    rx_state_t              w_next;
    logic [c_CYC_W-1:0]     r_cyc;
    logic [c_BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_pend;
    logic                   r_frm_pend;
    logic                   r_armed;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_overrun;

    logic w_s_in;
    logic w_fall;
    logic w_bit_dec;
    logic w_dec;
    logic w_start;
    logic w_busy;
    logic w_done;
    logic w_frm_final;
    logic w_par_exp;
    logic w_load;

    uart_bit_sampler #(
        .CYCLES_PER_SYMBOL (CYCLES_PER_SYMBOL),
        .CYC_W             (c_CYC_W)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .signal_in (signal_in),
        .cyc       (r_cyc),
        .s_in      (w_s_in),
        .fall      (w_fall),
        .bit_dec   (w_bit_dec)
    );

    // In IDLE r_cyc sits at 0, so the edge-detect cycle is bit phase 0.
    // That value can never equal MID+1 (>= 2), so w_dec is inert in IDLE.
    assign w_dec   = (r_cyc == c_DEC_CYC);
    assign w_start = (r_state == ST_IDLE) & w_fall & r_armed;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_START;
            ST_START:  if (w_dec)   w_next = w_bit_dec ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_dec && r_bit == c_LAST_DATA)
                           w_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_dec)   w_next = ST_STOP;
            ST_STOP:   if (w_dec && r_bit == c_LAST_STOP) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // ---------------- output / strobe logic ----------------
    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_done      = (r_state == ST_STOP) && w_dec && (r_bit == c_LAST_STOP);
        w_frm_final = r_frm_pend | ~w_bit_dec;
        // Parity bit value that makes the total ones count odd/even.
        w_par_exp   = (PARITY == PARITY_ODD) ? ~^r_shift : ^r_shift;
        w_load      = w_done & (~r_valid | data_ready);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_pend <= 1'b0;
            r_frm_pend <= 1'b0;
            r_armed    <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_next == ST_IDLE)        r_cyc <= '0;
            else if (r_state == ST_IDLE)  r_cyc <= c_CYC_W'(1);
            else if (r_cyc == c_LAST_CYC) r_cyc <= '0;
            else                          r_cyc <= r_cyc + 1'b1;

            if (w_start) begin
                r_bit      <= '0;
                r_par_pend <= 1'b0;
                r_frm_pend <= 1'b0;
            end else if (w_dec) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift <= {w_bit_dec, r_shift[DATA_BITS-1:1]};
                        r_bit   <= (r_bit == c_LAST_DATA) ? '0 : r_bit + 1'b1;
                    end
                    ST_PARITY: if (w_bit_dec != w_par_exp) r_par_pend <= 1'b1;
                    ST_STOP: begin
                        if (!w_bit_dec) r_frm_pend <= 1'b1;
                        r_bit <= r_bit + 1'b1;
                    end
                    default: ;
                endcase
            end

            // A framing error on a line still held low is a break: stay
            // disarmed until the line is seen idle again.
            if (w_done && w_frm_final && !w_s_in) r_armed <= 1'b0;
            else if (w_s_in)                      r_armed <= 1'b1;

            r_overrun <= w_done & ~w_load;
            if (w_load) begin
                r_data  <= r_shift;
                r_perr  <= r_par_pend;
                r_ferr  <= w_frm_final;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_overrun;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_os
//  Description : Self-checking bench for uart_rx_os. Three instances cover
//                8N1 @16, 8E1 @16 and 5N2 @4 cycles per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int CPS_T  [3] = '{16, 16, 4};
    localparam int DB_T   [3] = '{8, 8, 5};
    localparam int PAR_T  [3] = '{0, 2, 0};
    localparam int STOP_T [3] = '{1, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in [3];
    logic rdy    [3];
    int   cyc_cnt = 0;

    wire [7:0] dout_a;
    wire       dv_a, pe_a, fe_a, ov_a, bz_a;
    wire [7:0] dout_b;
    wire       dv_b, pe_b, fe_b, ov_b, bz_b;
    wire [4:0] dout_c;
    wire       dv_c, pe_c, fe_c, ov_c, bz_c;

    uart_rx_os #(.CYCLES_PER_SYMBOL(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .signal_in(sig_in[0]), .data_out(dout_a), .data_valid(dv_a),
        .data_ready(rdy[0]), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(bz_a));
    uart_rx_os #(.CYCLES_PER_SYMBOL(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .signal_in(sig_in[1]), .data_out(dout_b), .data_valid(dv_b),
        .data_ready(rdy[1]), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(bz_b));
    uart_rx_os #(.CYCLES_PER_SYMBOL(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .signal_in(sig_in[2]), .data_out(dout_c), .data_valid(dv_c),
        .data_ready(rdy[2]), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c), .busy(bz_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Word record: {parity_err, frame_err, data[8:0]}
    function automatic logic [10:0] f_word(input int w);
        case (w)
            0:       return {pe_a, fe_a, 1'b0, dout_a};
            1:       return {pe_b, fe_b, 1'b0, dout_b};
            default: return {pe_c, fe_c, 4'b0, dout_c};
        endcase
    endfunction
    function automatic logic f_dv(input int w);
        case (w) 0: return dv_a; 1: return dv_b; default: return dv_c; endcase
    endfunction
    function automatic logic f_ov(input int w);
        case (w) 0: return ov_a; 1: return ov_b; default: return ov_c; endcase
    endfunction

    // ---------------- monitor ----------------
    logic [10:0] got_v [3][128];
    int          got_n    [3] = '{0, 0, 0};
    int          hi_cnt   [3] = '{0, 0, 0};
    int          ovr_cnt  [3] = '{0, 0, 0};
    int          rise_cyc [3] = '{0, 0, 0};
    logic        dv_prev  [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) begin
            if (f_dv(w)) hi_cnt[w]++;
            if (f_dv(w) && rdy[w] && got_n[w] < 128) begin
                got_v[w][got_n[w]] = f_word(w);
                got_n[w]++;
            end
            if (f_ov(w)) ovr_cnt[w]++;
            if (f_dv(w) && !dv_prev[w]) rise_cyc[w] = cyc_cnt;
            dv_prev[w] = f_dv(w);
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [10:0] exp_v [3][128];
    int          exp_n  [3] = '{0, 0, 0};
    int          sb_idx [3] = '{0, 0, 0};
    int          last_start [3] = '{0, 0, 0};

    function automatic logic [8:0] mask_data(input int w, input logic [8:0] d);
        logic [8:0] m;
        m = (9'h1 << DB_T[w]) - 9'h1;
        return d & m;
    endfunction

    // Line bits, first bit on the wire in bit 0.
    function automatic logic [31:0] make_frame(input int w, input logic [8:0] d,
                                               input bit bad_par, input bit bad_stop,
                                               output int n);
        logic [31:0] f;
        int ones;
        f = '1;
        n = 0;
        f[n] = 1'b0; n = n + 1;
        ones = 0;
        for (int i = 0; i < DB_T[w]; i++) begin
            f[n] = d[i]; n = n + 1;
            ones = ones + int'(d[i]);
        end
        if (PAR_T[w] != 0) begin
            f[n] = ((PAR_T[w] == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ bad_par;
            n = n + 1;
        end
        for (int s = 0; s < STOP_T[w]; s++) begin
            f[n] = !(bad_stop && s == 0); n = n + 1;
        end
        return f;
    endfunction

    function automatic logic [10:0] exp_word(input int w, input logic [8:0] d,
                                             input bit bad_par, input bit bad_stop);
        return {(PAR_T[w] != 0) && bad_par, bad_stop, mask_data(w, d)};
    endfunction

    task automatic drive_bits(input int w, input logic [31:0] bits, input int n, input logic idle_level);
        for (int i = 0; i < n; i++) begin
            sig_in[w] = bits[i];
            repeat (CPS_T[w]) @(posedge clk);
            #1;
        end
        sig_in[w] = idle_level;
    endtask

    task automatic send_word(input int w, input logic [8:0] d, input bit bad_par,
                             input bit bad_stop, input bit expect_out, input logic idle_level);
        logic [31:0] f;
        int n;
        f = make_frame(w, d, bad_par, bad_stop, n);
        if (expect_out) begin
            exp_v[w][exp_n[w]] = exp_word(w, d, bad_par, bad_stop);
            exp_n[w]++;
        end
        last_start[w] = cyc_cnt;
        drive_bits(w, f, n, idle_level);
    endtask

    task automatic sb_check(input int w, input string name);
        repeat (3 * CPS_T[w] + 4) @(posedge clk);
        #1;
        check({name, " count"}, got_n[w], exp_n[w]);
        for (int i = sb_idx[w]; i < exp_n[w] && i < got_n[w]; i++)
            check($sformatf("%s[%0d]", name, i), got_v[w][i], exp_v[w][i]);
        sb_idx[w] = exp_n[w];
    endtask

    // ---------------- parity/framing vector table (8E1) ----------------
    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       stopb;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;
    vec_t tbl [8];

    int base_hi;
    int base_ov;

    initial begin
        tbl[0] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};

        sig_in = '{1'b1, 1'b1, 1'b1};
        rdy    = '{1'b1, 1'b1, 1'b1};
        rst    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset dv_a", dv_a, 0);
        check("reset dout_a", dout_a, 0);
        check("reset pe_a", pe_a, 0);
        check("reset fe_a", fe_a, 0);
        check("reset ov_a", ov_a, 0);
        check("reset busy_a", bz_a, 0);
        check("reset dv_c", dv_c, 0);
        check("reset dout_c", dout_c, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // 1: 8N1 0xA5, latency and single-cycle valid
        base_hi = hi_cnt[0];
        send_word(0, 9'h0A5, 0, 0, 1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("t1 latency from signal_in", rise_cyc[0] - last_start[0], 155);
        check("t1 valid cycles", hi_cnt[0] - base_hi, 1);
        sb_check(0, "t1 word");

        // 2: start glitch rejected, then a real frame
        base_hi = hi_cnt[0];
        sig_in[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sig_in[0] = 1'b1;
        @(negedge clk);
        check("t2 busy during glitch", bz_a, 1);
        repeat (20) @(posedge clk);
        #1;
        check("t2 busy after glitch", bz_a, 0);
        check("t2 no valid on glitch", hi_cnt[0] - base_hi, 0);
        send_word(0, 9'h03C, 0, 0, 1, 1'b1);
        sb_check(0, "t2 word");

        // 3: 8E1 table
        for (int i = 0; i < 8; i++) begin
            logic [31:0] f;
            f = {21'h1FFFFF, tbl[i].stopb, tbl[i].pbit, tbl[i].d, 1'b0};
            exp_v[1][exp_n[1]] = {tbl[i].exp_pe, tbl[i].exp_fe, 1'b0, tbl[i].d};
            exp_n[1]++;
            drive_bits(1, f, 11, 1'b1);
            repeat (2 * CPS_T[1]) @(posedge clk);
            #1;
        end
        sb_check(1, "t3 table");

        // 4: framing error followed by a long break
        send_word(0, 9'h055, 0, 1, 1, 1'b0);
        repeat (40 * 16) @(posedge clk);
        #1;
        sb_check(0, "t4 break word");
        sig_in[0] = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        send_word(0, 9'h012, 0, 0, 1, 1'b1);
        sb_check(0, "t4 after break");

        // 5: overrun with the sink stalled
        rdy[0] = 1'b0;
        base_ov = ovr_cnt[0];
        send_word(0, 9'h011, 0, 0, 1, 1'b1);
        send_word(0, 9'h022, 0, 0, 0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("t5 held word", dout_a, 8'h11);
        check("t5 valid held", dv_a, 1);
        check("t5 overrun pulses", ovr_cnt[0] - base_ov, 1);
        rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("t5 valid drops", dv_a, 0);
        sb_check(0, "t5 word");

        // 6a: 5N2 @4, all values back-to-back
        for (int v = 0; v < 32; v++) send_word(2, 9'(v), 0, 0, 1, 1'b1);
        sb_check(2, "t6 sweep");

        // 6b: reset in the middle of the data bits
        base_hi = hi_cnt[0];
        sig_in[0] = 1'b0;
        repeat (16 * 3) @(posedge clk);
        #1;
        check("t6 busy mid-frame", bz_a, 1);
        rst = 1'b1;
        sig_in[0] = 1'b1;
        @(posedge clk);
        #1;
        check("t6 busy after reset", bz_a, 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t6 no output after reset", hi_cnt[0] - base_hi, 0);
        send_word(0, 9'h05A, 0, 0, 1, 1'b1);
        sb_check(0, "t6 after reset");

        // Randomised traffic against the model
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 15; k++) begin
                logic [8:0] d;
                bit bp;
                d  = 9'($urandom);
                bp = (w == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
                send_word(w, d, bp, 0, 1, 1'b1);
                repeat ($urandom_range(0, 2 * CPS_T[w])) @(posedge clk);
                #1;
            end
            sb_check(w, $sformatf("random dut%0d", w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver and the successor to the current 8N1 receiver. It adds configurable data width, parity and stop bits, a 2-flop input synchroniser, 3-tap majority sampling, start-glitch rejection and error flags. Recovered words go to a sink over a valid/ready handshake that has defined overrun behaviour. The block sits between the board RX pin and a byte FIFO or consumer.

Parameters:
- CYCLES_PER_SYMBOL, 125_000_000/115_200: clk cycles per bit. Must be >= 4; elaboration fails otherwise.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits checked, >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- signal_in  in  1  asynchronous RX line, idles high.
- data_out  out  DATA_BITS  received word, bit 0 = first data bit on the line.
- data_valid  out  1  word held in data_out is valid.
- data_ready  in  1  sink accepts the word while data_valid is high.
- parity_err  out  1  qualified by data_valid; parity mismatch in the held word.
- frame_err  out  1  qualified by data_valid; at least one stop bit sampled low.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst sampled high at posedge clk):
  - state = IDLE; all outputs 0, except data_out, which also resets to 0.
  - Synchroniser and edge register are preset to 1.
  - Reset mid-frame abandons the frame silently with no flags.
- Synchroniser: s_in = signal_in delayed 2 flops. All timing below is relative to s_in.
- Counters:
  - cyc counts 0..CYCLES_PER_SYMBOL-1 and wraps.
  - It is cleared in the cycle a start edge is detected, so it is not free-running.
  - MID = (CYCLES_PER_SYMBOL-1)>>1.
- Bit decision: majority of s_in at cyc = MID-1, MID, MID+1, decided at cyc = MID+1.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - Armed only after s_in has been seen high (armed flag).
  - A falling edge (prev=1, s_in=0) while armed clears cyc and bit index, then goes to START.
- START: if the majority decision is 1, treat it as a glitch and return to IDLE with no output. If 0, go to DATA.
- DATA:
  - Shift decisions in LSB first.
  - After DATA_BITS decisions go to PARITY when PARITY != 0, else to STOP.
- PARITY:
  - Check the decision against XOR of the data bits: odd requires total ones odd, even requires total ones even.
  - A mismatch sets the pending parity flag.
- STOP:
  - STOP_BITS decisions; any 0 sets the pending frame flag.
  - At the last stop-bit decision, the frame completes and the state returns to IDLE in the next cycle.
  - The remaining half bit is not waited out, so back-to-back frames are caught.
- Latency:
  - Frame has N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
  - data_valid rises (N-1)*CYCLES_PER_SYMBOL + MID + 2 cycles after the start edge on s_in, i.e. 2 more after signal_in.
- Frame completion:
  - If data_valid=0, or data_valid & data_ready in the same cycle: load data_out, parity_err and frame_err, and set data_valid=1.
  - Otherwise keep the old word and flags, discard the new frame, and pulse overrun for 1 cycle.
- Handshake:
  - data_valid clears on a cycle with data_valid & data_ready, unless a new word loads in that same cycle.
  - data_out and the flags are stable while data_valid=1 and data_ready=0.
- Break handling: a frame error with the line held low sets armed=0, so no new start is detected until s_in returns high.
- Parity with PARITY=0: parity_err is always 0.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants.
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Width helper function: clog2 of CYCLES_PER_SYMBOL.
- Sub-module uart_bit_sampler: 2-flop synchroniser, edge detect and 3-tap majority. Outputs s_in, fall and bit_dec. The FSM, shifter and handshake stay in uart_rx_os.

Test Plan (CYCLES_PER_SYMBOL=16 unless noted; MID=7):
1. 8N1, send 0xA5, data_ready=1. Expect data_out=0xA5 with both flags 0. data_valid high exactly 153 cycles after the s_in start edge (155 after signal_in) for 1 cycle.
2. Glitch: signal_in low for 3 cycles, then high. Expect busy high then back to IDLE, and data_valid never asserts. Follow with 0x3C, which must be received correctly.
3. 8E1 (PARITY=2):
   - Send 0x07 with parity bit 0 (wrong). Expect data_out=0x07 and parity_err=1.
   - Resend with parity bit 1. Expect parity_err=0.
4. Framing/break: send 0x55 with the stop bit low and the line held low for 40 bit times. Expect frame_err=1 with the word, and no further data_valid until the line goes high and a fresh 0x12 frame arrives.
5. Overrun: data_ready=0, send 0x11 then 0x22 back-to-back. Expect data_out to stay 0x11 and overrun to pulse once at the second completion. After data_ready=1, data_valid drops the next cycle.
6. Variants:
   - CYCLES_PER_SYMBOL=4, DATA_BITS=5, STOP_BITS=2: send all 32 values back-to-back and expect exact match.
   - Assert rst mid-DATA: expect busy=0 the next cycle and no output; the next frame is received correctly.
